sweep_measure_sequencer: RTL and testbench
==========================================

// Module: sweep_measure_sequencer
// PURPOSE
//   Sequences one frequency sweep through the lock-in phase detector. For each sweep point it
//   loads a DDS frequency word, waits a settle time, then frames one accumulation window with
//   two trigger pulses. It collects the phase/magnitude result, streams it out and tracks the
//   peak-magnitude point. Sits between the host/config registers, the DDS and the phase detector.
// PARAMETERS
//   FREQ_W   32  DDS frequency word width (modulo-2^FREQ_W arithmetic)
//   IDX_W    12  sweep point index / count width
//   SET_W    16  settle counter width
//   WIN_W    20  accumulation window counter width
//   TIMEOUT  16  max cycles to wait for pd_valid after closing trigger
// PORTS
//   clk           in   1       system clock (50 MHz)
//   reset         in   1       asynchronous, active-high reset
//   start         in   1       1-cycle pulse: begin sweep (ignored while busy)
//   abort         in   1       level: terminate sweep
//   f_start       in   FREQ_W  first frequency word
//   f_step        in   FREQ_W  frequency increment per point
//   n_steps       in   IDX_W   number of points (0 = empty sweep)
//   settle_cyc    in   SET_W   cycles between freq_load and opening trigger
//   window_cyc    in   WIN_W   cycles between opening and closing trigger (min 2)
//   freq_word     out  FREQ_W  current DDS frequency word
//   freq_load     out  1       1-cycle strobe: freq_word valid, DDS must load it
//   pd_trigger    out  1       registered trigger to phase detector (1-cycle pulses only)
//   pd_phase      in   16      signed phase from detector, 0.01 deg
//   pd_mag        in   16      magnitude from detector
//   pd_valid      in   1       detector result strobe
//   res_valid     out  1       1-cycle strobe: res_* hold one point
//   res_index     out  IDX_W   point index 0..n_steps-1
//   res_phase     out  16      signed, copied from pd_phase
//   res_mag       out  16      copied from pd_mag
//   busy          out  1       high from accepted start until DONE/abort
//   done          out  1       1-cycle strobe at normal sweep completion
//   peak_index    out  IDX_W   index of largest res_mag this sweep
//   peak_freq     out  FREQ_W  freq_word of that point
//   peak_mag      out  16      largest res_mag this sweep
//   timeout_err   out  1       sticky: some point got no pd_valid; cleared on next start
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE. Config inputs latched on accepted start.
//   FSM: IDLE -start-> LOAD (n_steps=0: -> DONE directly, no trigger, no freq_load)
//     LOAD: freq_word <= f_start (idx 0) else freq_word+f_step (wraps mod 2^FREQ_W);
//           freq_load=1 one cycle; -> SETTLE
//     SETTLE: wait settle_cyc cycles (0 = none) -> TRIG_OPEN
//     TRIG_OPEN: pd_trigger=1 one cycle -> ACCUM
//     ACCUM: pd_trigger=0 for max(window_cyc,2)-1 cycles -> TRIG_CLOSE
//       (rising edges of pd_trigger are exactly max(window_cyc,2) cycles apart)
//     TRIG_CLOSE: pd_trigger=1 one cycle -> WAIT_RES
//     WAIT_RES: on pd_valid: res_* registered, res_valid next cycle; peak update if
//       pd_mag > peak_mag (strict; ties keep earlier point; first point always loads);
//       after TIMEOUT cycles w/o pd_valid: set timeout_err, no res_valid, no peak update
//       -> NEXT
//     NEXT: idx==n_steps-1 -> DONE else idx++ -> LOAD
//     DONE: done=1 one cycle, busy drops same cycle -> IDLE
//   pd_valid outside WAIT_RES ignored. start while busy ignored.
//   abort (priority over all): next cycle IDLE, pd_trigger=0, busy=0, no done, no
//     res_valid; peak_*/timeout_err keep last values. Reset mid-sweep identical but clears all.
//   Peak regs and timeout_err cleared on accepted start. Outputs all registered.
// STRUCTURE
//   Package sweep_pkg: state enum (IDLE,LOAD,SETTLE,TRIG_OPEN,ACCUM,TRIG_CLOSE,
//     WAIT_RES,NEXT,DONE), width constants, WIN_MIN=2.
//   Sub-module cycle_timer: loadable down-counter (width WIN_W, load/expired), one instance
//     shared by SETTLE, ACCUM and WAIT_RES timing. Peak tracker kept inline.
// TESTING (bench includes behavioural phase detector model)
//   1 f_start=1000,f_step=250,n_steps=3,settle=4,win=10 -> freq_load x3 with 1000,1250,1500;
//     6 trigger pulses, rising pairs 10 cycles apart; res_index 0,1,2; done once
//   2 model mags 5,9,9,3 (n=4) -> peak_index=1, peak_mag=9, peak_freq of idx1
//   3 n_steps=0 -> done 1-2 cycles after start, no freq_load, no pd_trigger
//   4 model drops pd_valid on idx1 (n=3) -> timeout_err=1, res_valid only for idx 0,2, done
//   5 abort during ACCUM -> next cycle busy=0, pd_trigger stays 0, no done; new start works
//   6 f_start=0xFFFFFF00,f_step=0x100,n=2; window_cyc=0 -> freq 0xFFFFFF00,0x0; triggers 2 apart

Source files
------------

// File: rtl/sweep_measure_sequencer_pkg.sv
// Shared types and constants for the sweep/measure sequencer.
package sweep_pkg;

  localparam int FREQ_W  = 32;
  localparam int IDX_W   = 12;
  localparam int SET_W   = 16;
  localparam int WIN_W   = 20;
  localparam int PD_W    = 16;
  localparam int TIMEOUT = 16;
  localparam int WIN_MIN = 2;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    TRIG_OPEN,
    ACCUM,
    TRIG_CLOSE,
    WAIT_RES,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/sweep_measure_sequencer_cycle_timer.sv
// Loadable down-counter shared by the settle, window and result-timeout phases.
// o_expired is high while the count sits at zero, so a load of N gives N+1 cycles.
module cycle_timer #(
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/sweep_measure_sequencer.sv
// Frequency-sweep sequencer: loads DDS words, frames lock-in windows with
// trigger pulses, streams results and tracks the peak-magnitude point.
//
// state      | meaning
// IDLE       | waiting for start, busy low
// LOAD       | compute next DDS word, strobe freq_load
// SETTLE     | let the DDS/analog path settle
// TRIG_OPEN  | opening trigger pulse
// ACCUM      | accumulation window, trigger low
// TRIG_CLOSE | closing trigger pulse
// WAIT_RES   | wait for detector result or timeout
// NEXT       | advance point index or finish
// DONE       | done strobe, busy drops
module sweep_measure_sequencer #(
  parameter int FREQ_W  = sweep_pkg::FREQ_W,
  parameter int IDX_W   = sweep_pkg::IDX_W,
  parameter int SET_W   = sweep_pkg::SET_W,
  parameter int WIN_W   = sweep_pkg::WIN_W,
  parameter int TIMEOUT = sweep_pkg::TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [FREQ_W-1:0] i_f_start,
  input  logic [FREQ_W-1:0] i_f_step,
  input  logic [IDX_W-1:0]  i_n_steps,
  input  logic [SET_W-1:0]  i_settle_cyc,
  input  logic [WIN_W-1:0]  i_window_cyc,
  output logic [FREQ_W-1:0] o_freq_word,
  output logic              o_freq_load,
  output logic              o_pd_trigger,
  input  logic [15:0]       i_pd_phase,
  input  logic [15:0]       i_pd_mag,
  input  logic              i_pd_valid,
  output logic              o_res_valid,
  output logic [IDX_W-1:0]  o_res_index,
  output logic [15:0]       o_res_phase,
  output logic [15:0]       o_res_mag,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_peak_index,
  output logic [FREQ_W-1:0] o_peak_freq,
  output logic [15:0]       o_peak_mag,
  output logic              o_timeout_err
);

  import sweep_pkg::*;

  state_t            r_state;
  logic [FREQ_W-1:0] r_f_start;
  logic [FREQ_W-1:0] r_f_step;
  logic [IDX_W-1:0]  r_n_steps;
  logic [SET_W-1:0]  r_settle;
  logic [WIN_W-1:0]  r_win;
  logic [IDX_W-1:0]  r_idx;
  logic [FREQ_W-1:0] r_freq_word;
  logic              r_freq_load;
  logic              r_pd_trigger;
  logic              r_res_valid;
  logic [IDX_W-1:0]  r_res_index;
  logic [15:0]       r_res_phase;
  logic [15:0]       r_res_mag;
  logic              r_busy;
  logic              r_done;
  logic [IDX_W-1:0]  r_peak_index;
  logic [FREQ_W-1:0] r_peak_freq;
  logic [15:0]       r_peak_mag;
  logic              r_peak_loaded;
  logic              r_timeout_err;

  logic              w_tmr_load;
  logic [WIN_W-1:0]  w_tmr_val;
  logic              w_tmr_expired;
  logic [WIN_W-1:0]  w_win_eff;

  // Windows shorter than WIN_MIN are stretched so both triggers stay distinct pulses.
  assign w_win_eff = (r_win < WIN_W'(WIN_MIN)) ? WIN_W'(WIN_MIN) : r_win;

  // Timer reload on entry to each timed phase; values are one less than the wanted cycle count.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      LOAD: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = WIN_W'(r_settle) - WIN_W'(1);
      end
      TRIG_OPEN: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = w_win_eff - WIN_W'(2);
      end
      TRIG_CLOSE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = WIN_W'(TIMEOUT - 1);
      end
      default: ;
    endcase
  end

  cycle_timer #(.WIDTH(WIN_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  // Sequencer FSM with registered strobes; abort overrides every state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_f_start     <= '0;
      r_f_step      <= '0;
      r_n_steps     <= '0;
      r_settle      <= '0;
      r_win         <= '0;
      r_idx         <= '0;
      r_freq_word   <= '0;
      r_freq_load   <= 1'b0;
      r_pd_trigger  <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_index   <= '0;
      r_res_phase   <= '0;
      r_res_mag     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_peak_index  <= '0;
      r_peak_freq   <= '0;
      r_peak_mag    <= '0;
      r_peak_loaded <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_freq_load  <= 1'b0;
      r_pd_trigger <= 1'b0;
      r_res_valid  <= 1'b0;
      r_done       <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_f_start     <= i_f_start;
              r_f_step      <= i_f_step;
              r_n_steps     <= i_n_steps;
              r_settle      <= i_settle_cyc;
              r_win         <= i_window_cyc;
              r_idx         <= '0;
              r_busy        <= 1'b1;
              r_peak_index  <= '0;
              r_peak_freq   <= '0;
              r_peak_mag    <= '0;
              r_peak_loaded <= 1'b0;
              r_timeout_err <= 1'b0;
              r_state       <= (i_n_steps == '0) ? DONE : LOAD;
            end
          end
          LOAD: begin
            r_freq_word <= (r_idx == '0) ? r_f_start : r_freq_word + r_f_step;
            r_freq_load <= 1'b1;
            r_state     <= (r_settle == '0) ? TRIG_OPEN : SETTLE;
          end
          SETTLE: begin
            if (w_tmr_expired) r_state <= TRIG_OPEN;
          end
          TRIG_OPEN: begin
            r_pd_trigger <= 1'b1;
            r_state      <= ACCUM;
          end
          ACCUM: begin
            if (w_tmr_expired) r_state <= TRIG_CLOSE;
          end
          TRIG_CLOSE: begin
            r_pd_trigger <= 1'b1;
            r_state      <= WAIT_RES;
          end
          WAIT_RES: begin
            if (i_pd_valid) begin
              r_res_valid <= 1'b1;
              r_res_index <= r_idx;
              r_res_phase <= i_pd_phase;
              r_res_mag   <= i_pd_mag;
              // Strict compare keeps the earliest point on ties.
              if (!r_peak_loaded || (i_pd_mag > r_peak_mag)) begin
                r_peak_loaded <= 1'b1;
                r_peak_index  <= r_idx;
                r_peak_freq   <= r_freq_word;
                r_peak_mag    <= i_pd_mag;
              end
              r_state <= NEXT;
            end else if (w_tmr_expired) begin
              r_timeout_err <= 1'b1;
              r_state       <= NEXT;
            end
          end
          NEXT: begin
            if (r_idx == r_n_steps - IDX_W'(1)) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= LOAD;
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_freq_word   = r_freq_word;
  assign o_freq_load   = r_freq_load;
  assign o_pd_trigger  = r_pd_trigger;
  assign o_res_valid   = r_res_valid;
  assign o_res_index   = r_res_index;
  assign o_res_phase   = r_res_phase;
  assign o_res_mag     = r_res_mag;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_peak_index  = r_peak_index;
  assign o_peak_freq   = r_peak_freq;
  assign o_peak_mag    = r_peak_mag;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sweep_measure_sequencer.sv
// Bench for sweep_measure_sequencer with a behavioural phase-detector model
// and a result scoreboard.
module tb_sweep_measure_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [31:0] f_start, f_step;
  logic [11:0] n_steps;
  logic [15:0] settle_cyc;
  logic [19:0] window_cyc;
  logic [31:0] freq_word;
  logic        freq_load, pd_trigger;
  logic [15:0] pd_phase, pd_mag;
  logic        pd_valid;
  logic        res_valid;
  logic [11:0] res_index;
  logic [15:0] res_phase, res_mag;
  logic        busy, done;
  logic [11:0] peak_index;
  logic [31:0] peak_freq;
  logic [15:0] peak_mag;
  logic        timeout_err;

  always #10 clk = ~clk;

  sweep_measure_sequencer dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_abort       (abort),
    .i_f_start     (f_start),
    .i_f_step      (f_step),
    .i_n_steps     (n_steps),
    .i_settle_cyc  (settle_cyc),
    .i_window_cyc  (window_cyc),
    .o_freq_word   (freq_word),
    .o_freq_load   (freq_load),
    .o_pd_trigger  (pd_trigger),
    .i_pd_phase    (pd_phase),
    .i_pd_mag      (pd_mag),
    .i_pd_valid    (pd_valid),
    .o_res_valid   (res_valid),
    .o_res_index   (res_index),
    .o_res_phase   (res_phase),
    .o_res_mag     (res_mag),
    .o_busy        (busy),
    .o_done        (done),
    .o_peak_index  (peak_index),
    .o_peak_freq   (peak_freq),
    .o_peak_mag    (peak_mag),
    .o_timeout_err (timeout_err)
  );

  typedef struct {
    logic [31:0]      fs;
    logic [31:0]      fd;
    logic [11:0]      n;
    logic [15:0]      st;
    logic [19:0]      win;
    logic [3:0]       drop;
    logic [3:0][15:0] mags;
    logic [11:0]      pk_idx;
    logic [15:0]      pk_mag;
    logic [31:0]      pk_freq;
    logic             to;
    int               nres;
  } vec_t;

  typedef struct {
    logic [11:0] idx;
    logic [15:0] ph;
    logic [15:0] mag;
  } res_t;

  vec_t             vecs[4];
  res_t             exp_q[$];
  logic [31:0]      fl_q[$];
  int               fl_cyc_q[$];
  int               trig_q[$];
  int               cyc, res_cnt, done_cnt, trig_cnt, pend, spur, pend_pt;
  logic [3:0]       m_drop;
  logic [3:0][15:0] m_mags;
  int               total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Phase-detector model plus output monitor, run once per falling edge.
  task automatic mon_loop();
    res_t r;
    forever begin
      @(negedge clk);
      cyc++;
      pd_valid = 1'b0;
      if (spur > 0) begin
        spur--;
        if (spur == 0) begin
          pd_valid = 1'b1;
          pd_mag   = 16'hFFFF;
          pd_phase = 16'h7FFF;
        end
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          pd_valid = 1'b1;
          pd_mag   = m_mags[pend_pt];
          pd_phase = 16'hF000 + 16'(pend_pt * 3);
          exp_q.push_back('{12'(pend_pt), pd_phase, pd_mag});
        end
      end
      if (pd_trigger) begin
        trig_q.push_back(cyc);
        if (trig_cnt % 2 == 1) begin
          if (!m_drop[trig_cnt / 2]) begin
            pend    = 3;
            pend_pt = trig_cnt / 2;
          end
        end else begin
          spur = 1;
        end
        trig_cnt++;
      end
      if (freq_load) begin
        fl_q.push_back(freq_word);
        fl_cyc_q.push_back(cyc);
      end
      if (done) done_cnt++;
      if (res_valid) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_unexpected index=%0d required=no result", res_index);
        end else begin
          r = exp_q.pop_front();
          chk("res_index", 32'(res_index), 32'(r.idx));
          chk("res_phase", 32'(res_phase), 32'(r.ph));
          chk("res_mag", 32'(res_mag), 32'(r.mag));
        end
      end
    end
  endtask

  task automatic prep(input logic [3:0] drop, input logic [3:0][15:0] mags);
    @(posedge clk);
    exp_q.delete();
    fl_q.delete();
    fl_cyc_q.delete();
    trig_q.delete();
    res_cnt  = 0;
    done_cnt = 0;
    trig_cnt = 0;
    pend     = 0;
    spur     = 0;
    m_drop   = drop;
    m_mags   = mags;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL %s done not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   k, w;
    v = vecs[vi];
    prep(v.drop, v.mags);
    @(negedge clk);
    f_start = v.fs; f_step = v.fd; n_steps = v.n;
    settle_cyc = v.st; window_cyc = v.win; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // A second start mid-sweep must be ignored.
    k = 0;
    while (trig_cnt == 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    f_start = v.fs ^ 32'h5A5A_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done($sformatf("v%0d_done", vi), 2000);
    repeat (4) @(negedge clk);
    w = (v.win < 20'd2) ? 2 : int'(v.win);
    chk($sformatf("v%0d_freq_loads", vi), 32'(fl_q.size()), 32'(v.n));
    for (int i = 0; i < fl_q.size() && i < int'(v.n); i++)
      chk($sformatf("v%0d_freq%0d", vi, i), fl_q[i], 32'(v.fs + v.fd * 32'(i)));
    chk($sformatf("v%0d_triggers", vi), 32'(trig_q.size()), 32'(2 * int'(v.n)));
    for (int i = 0; i < int'(v.n) && 2 * i + 1 < trig_q.size() && i < fl_cyc_q.size(); i++) begin
      chk($sformatf("v%0d_win_gap%0d", vi, i), 32'(trig_q[2*i+1] - trig_q[2*i]), 32'(w));
      chk($sformatf("v%0d_settle_gap%0d", vi, i), 32'(trig_q[2*i] - fl_cyc_q[i]), 32'(int'(v.st) + 1));
    end
    chk($sformatf("v%0d_res_count", vi), 32'(res_cnt), 32'(v.nres));
    chk($sformatf("v%0d_sb_empty", vi), 32'(exp_q.size()), 32'd0);
    chk($sformatf("v%0d_done_count", vi), 32'(done_cnt), 32'd1);
    chk($sformatf("v%0d_busy", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d_peak_index", vi), 32'(peak_index), 32'(v.pk_idx));
    chk($sformatf("v%0d_peak_mag", vi), 32'(peak_mag), 32'(v.pk_mag));
    chk($sformatf("v%0d_peak_freq", vi), peak_freq, v.pk_freq);
    chk($sformatf("v%0d_timeout_err", vi), 32'(timeout_err), 32'(v.to));
  endtask

  initial begin
    int k;
    total = 0; bad = 0; cyc = 0;
    res_cnt = 0; done_cnt = 0; trig_cnt = 0; pend = 0; spur = 0; pend_pt = 0;
    m_drop = '0; m_mags = '0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = '0; f_step = '0; n_steps = '0; settle_cyc = '0; window_cyc = '0;
    pd_phase = '0; pd_mag = '0; pd_valid = 1'b0;

    //           fs            fd         n      st     win    drop     mags {3,2,1,0}                        pk_idx pk_mag  pk_freq       to  nres
    vecs[0] = '{32'd1000,     32'd250,   12'd3, 16'd4, 20'd10, 4'b0000, {16'd0, 16'd10, 16'd30, 16'd20},      12'd1, 16'd30, 32'd1250,     1'b0, 3};
    vecs[1] = '{32'd5000,     32'd100,   12'd4, 16'd2, 20'd5,  4'b0000, {16'd3, 16'd9,  16'd9,  16'd5},       12'd1, 16'd9,  32'd5100,     1'b0, 4};
    vecs[2] = '{32'd2000,     32'd500,   12'd3, 16'd1, 20'd3,  4'b0010, {16'd0, 16'd4,  16'd50, 16'd7},       12'd0, 16'd7,  32'd2000,     1'b0, 2};
    vecs[3] = '{32'hFFFFFF00, 32'h100,   12'd2, 16'd0, 20'd0,  4'b0000, {16'd0, 16'd0,  16'd2,  16'd1},       12'd1, 16'd2,  32'h0,        1'b0, 2};
    vecs[2].to = 1'b1;

    fork
      mon_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_freq_word", freq_word, 32'd0);
    chk("rst_freq_load", 32'(freq_load), 32'd0);
    chk("rst_pd_trigger", 32'(pd_trigger), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_peak_mag", 32'(peak_mag), 32'd0);
    chk("rst_peak_freq", peak_freq, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Empty sweep: done two edges after start, nothing else.
    prep(4'b0000, '0);
    @(negedge clk);
    f_start = 32'd77; f_step = 32'd1; n_steps = 12'd0; settle_cyc = 16'd3; window_cyc = 20'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_busy_1", 32'(busy), 32'd1);
    chk("empty_done_1", 32'(done), 32'd0);
    @(negedge clk);
    chk("empty_done_2", 32'(done), 32'd1);
    chk("empty_busy_2", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("empty_freq_loads", 32'(fl_q.size()), 32'd0);
    chk("empty_triggers", 32'(trig_q.size()), 32'd0);
    chk("empty_done_count", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Abort inside the second point's accumulation window.
    prep(4'b0000, {16'd0, 16'd0, 16'd44, 16'd33});
    @(negedge clk);
    f_start = 32'd7000; f_step = 32'd10; n_steps = 12'd3; settle_cyc = 16'd2; window_cyc = 20'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (trig_cnt < 3 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("abort_reached_accum", 32'(trig_cnt), 32'd3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_trigger", 32'(pd_trigger), 32'd0);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_triggers", 32'(trig_q.size()), 32'd3);
    chk("abort_freq_loads", 32'(fl_q.size()), 32'd2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_res_count", 32'(res_cnt), 32'd1);
    chk("abort_busy_late", 32'(busy), 32'd0);
    chk("abort_peak_mag", 32'(peak_mag), 32'd33);
    chk("abort_peak_index", 32'(peak_index), 32'd0);
    chk("abort_peak_freq", peak_freq, 32'd7000);

    // A fresh sweep after abort must run normally and clear the old peak.
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
